// File: rtl/mux2_arbiter_pkg.sv
// mux2_arbiter_pkg
//   Shared types and constants for the two-requester round-robin arbiter.
//   arb_state_t : FSM state encoding (IDLE, GRANT_A, GRANT_B)
//   SEL_A/SEL_B : mux select / priority pointer encodings
package mux2_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } arb_state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_arbiter_mux2_1.sv
// mux2_1
//   Single-bit structural 2:1 mux cell.
//   in0_i : selected when sel_i = 0
//   in1_i : selected when sel_i = 1
//   sel_i : select
//   y_o   : output
module mux2_1 (
   input  logic in0_i,
   input  logic in1_i,
   input  logic sel_i,
   output logic y_o
);

   assign y_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter
//   Packet-aware round-robin arbiter sharing one output channel between two
//   valid/ready requesters. The grant is held until the granted requester's
//   last beat is accepted; the selected beat is registered into a one-deep
//   output stage.
//
//   Optional feature macro: MUX2_ARBITER_TIMEOUT_EN
//     When defined, a stall counter forces release of the grant after
//     TIMEOUT consecutive granted cycles without a valid beat, pulsing err.
//     When undefined, err is tied to 0 and the grant is held until last.
//
//   Ports
//     clk, rst                 : clock, async active-high reset
//     a_valid/a_data/a_last    : requester A beat
//     a_ready                  : requester A accept
//     b_valid/b_data/b_last    : requester B beat
//     b_ready                  : requester B accept
//     out_valid/data/last      : registered output beat
//     out_ready                : consumer accept
//     sel                      : current grant (0 = A, 1 = B)
//     busy                     : packet in progress
//     err                      : one-cycle timeout-release pulse
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | no grant; arbitrate between pending requesters
//   GRANT_A | A owns the channel until its last beat
//   GRANT_B | B owns the channel until its last beat
module mux2_arbiter
   import mux2_arbiter_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_last,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_last,
   output logic             b_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   input  logic             out_ready,
   output logic             sel,
   output logic             busy,
   output logic             err
);

   arb_state_t       state_q;
   logic             sel_q;
   logic             ptr_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic             out_last_q;

   logic             load_en;
   logic             gnt_a;
   logic             gnt_b;
   logic             gvalid;
   logic             accept;
   logic             tmo_hit;
   logic [WIDTH:0]   a_bus;
   logic [WIDTH:0]   b_bus;
   logic [WIDTH:0]   mux_y;

   assign load_en = !out_valid_q || out_ready;
   assign gnt_a   = (state_q == GRANT_A);
   assign gnt_b   = (state_q == GRANT_B);
   assign a_ready = gnt_a && load_en;
   assign b_ready = gnt_b && load_en;
   assign gvalid  = gnt_a ? a_valid : b_valid;
   assign accept  = (a_ready && a_valid) || (b_ready && b_valid);

   // Bit WIDTH carries the last flag alongside the data bits.
   assign a_bus = {a_last, a_data};
   assign b_bus = {b_last, b_data};

   for (genvar i = 0; i <= WIDTH; i++) begin : g_mux
      mux2_1 u_mux (
         .in0_i (a_bus[i]),
         .in1_i (b_bus[i]),
         .sel_i (sel_q),
         .y_o   (mux_y[i])
      );
   end

`ifdef MUX2_ARBITER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] tmo_q;

   // Down-counter reloaded whenever the granted requester shows valid (or in
   // IDLE); release happens on the stall cycle that reaches terminal count.
   assign tmo_hit = (gnt_a || gnt_b) && !gvalid && (tmo_q == CW'(1));
   assign err     = tmo_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= CW'(TIMEOUT);
      end else if ((state_q == IDLE) || gvalid) begin
         tmo_q <= CW'(TIMEOUT);
      end else if (tmo_q != CW'(1)) begin
         tmo_q <= tmo_q - CW'(1);
      end
   end
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT == 0);
   assign tmo_hit    = 1'b0;
   assign err        = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sel_q       <= SEL_A;
         ptr_q       <= SEL_B;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // ptr_q holds the requester served last; the other wins ties.
               if (a_valid && (!b_valid || (ptr_q == SEL_B))) begin
                  state_q <= GRANT_A;
                  sel_q   <= SEL_A;
               end else if (b_valid) begin
                  state_q <= GRANT_B;
                  sel_q   <= SEL_B;
               end
            end
            GRANT_A: begin
               if ((a_ready && a_valid && a_last) || tmo_hit) begin
                  state_q <= IDLE;
                  ptr_q   <= SEL_A;
               end
            end
            GRANT_B: begin
               if ((b_ready && b_valid && b_last) || tmo_hit) begin
                  state_q <= IDLE;
                  ptr_q   <= SEL_B;
               end
            end
            default: state_q <= IDLE;
         endcase

         if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mux_y[WIDTH-1:0];
            out_last_q  <= mux_y[WIDTH];
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign sel       = sel_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mux2_arbiter.sv
module tb_mux2_arbiter;

   logic       clk;
   logic       rst;
   logic       a_valid, a_last, a_ready;
   logic [7:0] a_data;
   logic       b_valid, b_last, b_ready;
   logic [7:0] b_data;
   logic       out_valid, out_last, out_ready;
   logic [7:0] out_data;
   logic       sel, busy, err;

   int n_vec;
   int n_err;

   mux2_arbiter #(.WIDTH(8), .TIMEOUT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_valid   (a_valid),
      .a_data    (a_data),
      .a_last    (a_last),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_data    (b_data),
      .b_last    (b_last),
      .b_ready   (b_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .sel       (sel),
      .busy      (busy),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      a_valid = 1'b0; a_data = '0; a_last = 1'b0;
      b_valid = 1'b0; b_data = '0; b_last = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      a_valid = 1'b1; a_data = 8'hFF; a_last = 1'b1;
      b_valid = 1'b1; b_data = 8'hFF; b_last = 1'b1;
      out_ready = 1'b1;
      cyc();
      cyc();
      n_vec++;
      if ({out_valid, out_data, out_last, sel, busy, err, a_ready, b_ready} !== 14'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got v=%b d=%h l=%b sel=%b busy=%b err=%b ar=%b br=%b, expected all 0",
                  out_valid, out_data, out_last, sel, busy, err, a_ready, b_ready);
      end
   endtask

   task automatic test_single_packet;
      logic [7:0] beats [3];
      beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
      do_reset();
      a_valid = 1'b1; a_data = beats[0]; a_last = 1'b0;
      cyc();
      n_vec++;
      if (sel !== 1'b0 || busy !== 1'b1 || a_ready !== 1'b1) begin
         n_err++;
         $display("FAIL single_grant: got sel=%b busy=%b ar=%b, expected 0 1 1", sel, busy, a_ready);
      end
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_vec++;
         if (out_valid !== 1'b1 || out_data !== beats[i] || out_last !== (i == 2)) begin
            n_err++;
            $display("FAIL single_beat%0d: got v=%b d=%h l=%b, expected 1 %h %b",
                     i, out_valid, out_data, out_last, beats[i], (i == 2));
         end
         if (i < 2) begin
            a_data = beats[i+1];
            a_last = (i == 1);
         end
      end
      a_valid = 1'b0;
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL single_idle: got busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_round_robin;
      int  npk;
      int  a_idx, b_idx;
      logic ra, rb;
      logic exp_order [4];
      exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
      do_reset();
      npk = 0; a_idx = 0; b_idx = 0;
      a_valid = 1'b1; a_data = 8'hA0; a_last = 1'b0;
      b_valid = 1'b1; b_data = 8'hB0; b_last = 1'b0;
      for (int c = 0; c < 60 && npk < 4; c++) begin
         ra = a_ready;
         rb = b_ready;
         n_vec++;
         if (sel === 1'b0 && rb !== 1'b0) begin
            n_err++;
            $display("FAIL rr_b_ready_when_sel_a: got b_ready=%b, expected 0", rb);
         end
         cyc();
         if (ra) begin
            if (a_idx % 2 == 0) begin
               n_vec++;
               if (exp_order[npk] !== 1'b0) begin
                  n_err++;
                  $display("FAIL rr_order%0d: got A, expected %s", npk, exp_order[npk] ? "B" : "A");
               end
               npk++;
            end
            n_vec++;
            if (out_data !== a_data) begin
               n_err++;
               $display("FAIL rr_a_data: got %h, expected %h", out_data, a_data);
            end
            a_idx++;
            a_data = 8'hA0 + 8'(a_idx);
            a_last = (a_idx % 2 == 1);
         end
         if (rb) begin
            if (b_idx % 2 == 0) begin
               n_vec++;
               if (exp_order[npk] !== 1'b1) begin
                  n_err++;
                  $display("FAIL rr_order%0d: got B, expected %s", npk, exp_order[npk] ? "B" : "A");
               end
               npk++;
            end
            n_vec++;
            if (out_data !== b_data) begin
               n_err++;
               $display("FAIL rr_b_data: got %h, expected %h", out_data, b_data);
            end
            b_idx++;
            b_data = 8'hB0 + 8'(b_idx);
            b_last = (b_idx % 2 == 1);
         end
      end
      n_vec++;
      if (npk != 4) begin
         n_err++;
         $display("FAIL rr_budget: got %0d packets, expected 4", npk);
      end
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic test_backpressure;
      do_reset();
      a_valid = 1'b1; a_data = 8'hA1; a_last = 1'b0;
      cyc();
      cyc();
      out_ready = 1'b0;
      a_data = 8'hA2;
      for (int i = 0; i < 5; i++) begin
         #2;
         n_vec++;
         if (a_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hA1) begin
            n_err++;
            $display("FAIL bp_stall%0d: got ar=%b v=%b d=%h, expected 0 1 a1",
                     i, a_ready, out_valid, out_data);
         end
         cyc();
      end
      out_ready = 1'b1;
      #1;
      n_vec++;
      if (a_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_resume_ready: got %b, expected 1", a_ready);
      end
      cyc();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 8'hA2) begin
         n_err++;
         $display("FAIL bp_beat2: got v=%b d=%h, expected 1 a2", out_valid, out_data);
      end
      a_data = 8'hA3; a_last = 1'b1;
      cyc();
      n_vec++;
      if (out_data !== 8'hA3 || out_last !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL bp_beat3: got d=%h l=%b busy=%b, expected a3 1 0", out_data, out_last, busy);
      end
      a_valid = 1'b0;
      cyc();
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== 8'hA3) begin
         n_err++;
         $display("FAIL bp_drain: got v=%b d=%h, expected 0 a3", out_valid, out_data);
      end
   endtask

   task automatic test_back_to_back;
      int acc;
      do_reset();
      acc = 0;
      b_valid = 1'b1; b_last = 1'b1; b_data = 8'h5B;
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if (b_ready !== (i % 2 == 1)) begin
            n_err++;
            $display("FAIL b2b_ready%0d: got %b, expected %b", i, b_ready, (i % 2 == 1));
         end
         if (b_ready) acc++;
         cyc();
         n_vec++;
         if (sel !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_sel%0d: got %b, expected 1", i, sel);
         end
      end
      n_vec++;
      if (acc != 4) begin
         n_err++;
         $display("FAIL b2b_count: got %0d accepts, expected 4", acc);
      end
      b_valid = 1'b0; b_last = 1'b0;
   endtask

   task automatic test_reset_mid_packet;
      do_reset();
      a_valid = 1'b1; a_data = 8'h5A; a_last = 1'b1;
      cyc();
      cyc();
      a_data = 8'h55; a_last = 1'b0;
      cyc();
      cyc();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 8'h55 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL rst_mid_pre: got v=%b d=%h busy=%b, expected 1 55 1", out_valid, out_data, busy);
      end
      rst = 1'b1;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00 || a_ready !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_clear: got v=%b busy=%b d=%h ar=%b, expected 0 0 00 0",
                  out_valid, busy, out_data, a_ready);
      end
      b_valid = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc();
      n_vec++;
      if (sel !== 1'b0 || busy !== 1'b1 || a_ready !== 1'b1 || b_ready !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_tie: got sel=%b busy=%b ar=%b br=%b, expected 0 1 1 0",
                  sel, busy, a_ready, b_ready);
      end
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

`ifdef MUX2_ARBITER_TIMEOUT_EN
   task automatic test_timeout;
      do_reset();
      a_valid = 1'b1; a_data = 8'h61; a_last = 1'b0;
      cyc();
      cyc();
      a_valid = 1'b0; b_valid = 1'b1; b_data = 8'h62; b_last = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_vec++;
         if (err !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_stall%0d: got err=%b busy=%b, expected 0 1", i, err, busy);
         end
         cyc();
      end
      #1;
      n_vec++;
      if (err !== 1'b1 || busy !== 1'b1 || sel !== 1'b0) begin
         n_err++;
         $display("FAIL tmo_pulse: got err=%b busy=%b sel=%b, expected 1 1 0", err, busy, sel);
      end
      cyc();
      n_vec++;
      if (err !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
         n_err++;
         $display("FAIL tmo_idle: got err=%b busy=%b last=%b, expected 0 0 0", err, busy, out_last);
      end
      cyc();
      n_vec++;
      if (sel !== 1'b1 || busy !== 1'b1 || b_ready !== 1'b1) begin
         n_err++;
         $display("FAIL tmo_grant_b: got sel=%b busy=%b br=%b, expected 1 1 1", sel, busy, b_ready);
      end
      b_valid = 1'b0; b_last = 1'b0;
   endtask
`else
   task automatic test_hold_no_timeout;
      do_reset();
      a_valid = 1'b1; a_data = 8'h61; a_last = 1'b0;
      cyc();
      cyc();
      a_valid = 1'b0; b_valid = 1'b1; b_last = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         n_vec++;
         if (err !== 1'b0 || busy !== 1'b1 || sel !== 1'b0 || b_ready !== 1'b0) begin
            n_err++;
            $display("FAIL hold%0d: got err=%b busy=%b sel=%b br=%b, expected 0 1 0 0",
                     i, err, busy, sel, b_ready);
         end
         cyc();
      end
      b_valid = 1'b0; b_last = 1'b0;
   endtask
`endif

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_single_packet();
      test_round_robin();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_packet();
`ifdef MUX2_ARBITER_TIMEOUT_EN
      test_timeout();
`else
      test_hold_no_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
Round-robin, packet-aware arbiter that shares one output channel between two valid/ready requesters (A, B).
- Drives the select of a per-bit 2:1 data mux and holds the grant until the granted requester sends its `last` beat.
- Registers the selected beat into a one-deep output stage.
- Sits in front of any single-consumer resource that two producers must share.

Parameters:
- WIDTH, 8: data bits per beat.
- TIMEOUT, 15: stall cycles allowed mid-packet before forced release. Used only with the optional feature. Minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- a_valid  in  1  requester A has a beat.
- a_data  in  WIDTH  requester A beat data.
- a_last  in  1  beat is the final beat of A's packet.
- a_ready  out  1  A beat accepted this cycle when a_valid && a_ready.
- b_valid, b_data, b_last, b_ready: same as A, for requester B.
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  registered beat data.
- out_last  out  1  registered last flag.
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready.
- sel  out  1  current grant: 0 = A, 1 = B. Drives the mux select.
- busy  out  1  a packet is in progress (state is not IDLE).
- err  out  1  one-cycle pulse on timeout release. Constant 0 when the feature is compiled out.

Behaviour:
- Single clock; rst is asynchronous and active-high.
- Reset values: state = IDLE, sel = 0, busy = 0, out_valid = 0, out_data = 0, out_last = 0, err = 0, a_ready = b_ready = 0, priority pointer = B-last-served (A wins the first tie).
- FSM states: IDLE, GRANT_A, GRANT_B.
- IDLE transitions:
  - only a_valid -> GRANT_A.
  - only b_valid -> GRANT_B.
  - both valid -> grant the requester not served last.
  - neither -> stay in IDLE.
  - sel updates on entry to a GRANT state and holds its value in IDLE.
- Arbitration latency: one cycle. No beat is accepted in IDLE. First accept is possible in the cycle after valid is seen.
- load_en = !out_valid || out_ready.
- a_ready = (state == GRANT_A) && load_en; b_ready likewise for GRANT_B. The ready of the non-granted requester is always 0.
- On accept: out_data/out_last load from the granted requester through the mux; out_valid = 1.
- When out_ready && out_valid with no new accept, out_valid clears to 0. out_data/out_last hold their values.
- Accepting a beat with last = 1:
  - state -> IDLE;
  - priority pointer := the granted requester;
  - the grant is not retained.
  - A back-to-back packet from the same requester re-arbitrates, and loses to a pending other requester.
- Backpressure: while out_ready = 0 and out_valid = 1, the granted ready is 0. No beat is dropped or duplicated.
- Full throughput inside a packet: 1 beat/cycle when out_ready is held at 1.
- Valid deasserted mid-packet: the grant is held indefinitely, unless the optional feature is enabled.
- Single-beat packet (valid && last on the first accept): returns to IDLE the next cycle. Sustained rate is therefore 1 packet per 2 cycles.
- Reset mid-packet: immediate return to reset values. A beat in the output register is discarded.
- busy = (state != IDLE).

Optional Feature:
Macro: MUX2_ARBITER_TIMEOUT_EN.
- Defined:
  - A stall counter (width $clog2(TIMEOUT+1)) counts consecutive GRANT-state cycles in which the granted valid = 0.
  - The counter clears on any accept and in IDLE.
  - On reaching TIMEOUT: state -> IDLE, pointer := the granted requester, err pulses high for 1 cycle.
  - out_last of the already-accepted beats is not modified.
- Undefined: no counter is built, err is tied to 0, and the grant is held until last.

Decomposition:
- Package mux2_arbiter_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, GRANT_A, GRANT_B};
  - constants SEL_A = 1'b0, SEL_B = 1'b1.
- Sub-module: the data/last path reuses the team's structural mux2_1 cell, instantiated WIDTH+1 times in a generate loop, with sel from the FSM.
- All sequencing stays in mux2_arbiter.

Test Plan:
1. Reset -> all outputs at reset values. Release rst, a_valid = 1, data 0x11/0x22/0x33 with last on 0x33, out_ready = 1 -> sel = 0 from cycle 1, out_data sequence 0x11, 0x22, 0x33 on consecutive cycles, then busy = 0.
2. a_valid and b_valid both high from reset, 2-beat packets each, repeated -> grant order A, B, A, B. b_ready is never 1 while sel = 0.
3. Grant A, out_ready = 0 for 5 cycles mid-packet -> a_ready = 0 and out_data stable for those cycles. Resume -> no beat lost or duplicated.
4. B single-beat packets back-to-back (b_valid and b_last held high) with A idle -> one accept every 2 cycles, sel = 1 throughout.
5. Grant A after 1 beat accepted, assert rst for 1 cycle -> out_valid = 0, busy = 0, state IDLE. Next tie goes to A.
6. With MUX2_ARBITER_TIMEOUT_EN and TIMEOUT = 4: A accepts 1 non-last beat, then a_valid = 0, b_valid = 1 -> err pulses in the 4th stall cycle, grant moves to B one cycle after IDLE.
